// File: rtl/fetch.sv
// Instruction fetch front end: credit-limited sequential requests to imem,
// in-order buffering of returned words, redirect flush with stale-response drop.
package fetch_pkg;
  typedef logic [31:0] t_rv_instr;
endpackage

module fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IBUF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_if,
  output logic [31:0] imem_addr_if,
  input  logic        imem_gnt_if,
  input  logic        imem_rsp_valid_if,
  input  logic [31:0] imem_rsp_data_if,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        valid_de0,
  output t_rv_instr   instr_de0,
  output logic [31:0] pc_de0,
  input  logic        stall_de0
);
  localparam int PW = $clog2(IBUF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW+1:0] CREDIT_MAX = (CW+2)'(IBUF_DEPTH);

  typedef struct packed {
    t_rv_instr   instr;
    logic [31:0] pc;
  } ibuf_ent_t;

  ibuf_ent_t      ibuf [IBUF_DEPTH];
  logic [PW-1:0]  rd_ptr, wr_ptr;
  logic [CW-1:0]  count, outstanding, drop_cnt;
  logic [31:0]    fetch_pc, rsp_pc, redir_tgt;
  logic [CW+1:0]  credit_used;
  logic           fire, rsp_drop, rsp_keep, push, pop;

  assign redir_tgt   = redirect_pc & ~32'd3;
  // Every granted request owns a slot until it is popped or its response is dropped.
  assign credit_used = {2'b00, outstanding} + {2'b00, drop_cnt} + {2'b00, count};
  assign imem_req_if  = !reset && !redirect_valid && (credit_used < CREDIT_MAX);
  assign imem_addr_if = fetch_pc;

  assign fire     = imem_req_if && imem_gnt_if;
  assign rsp_drop = imem_rsp_valid_if && (drop_cnt != '0);
  assign rsp_keep = imem_rsp_valid_if && (drop_cnt == '0);
  assign push     = rsp_keep && !redirect_valid;
  assign pop      = valid_de0 && !stall_de0;

  assign valid_de0 = (count != '0);
  assign instr_de0 = ibuf[rd_ptr].instr;
  assign pc_de0    = ibuf[rd_ptr].pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      for (int i = 0; i < IBUF_DEPTH; i++) ibuf[i] <= '{instr: '0, pc: RESET_PC};
    end else if (redirect_valid) begin
      fetch_pc    <= redir_tgt;
      rsp_pc      <= redir_tgt;
      outstanding <= '0;
      // A response in this cycle retires one slot whether it was already doomed or not.
      drop_cnt    <= drop_cnt + outstanding - CW'(imem_rsp_valid_if);
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      if (fire) fetch_pc <= fetch_pc + 32'd4;
      outstanding <= outstanding + CW'(fire) - CW'(rsp_keep);
      if (rsp_drop) drop_cnt <= drop_cnt - 1'b1;
      if (push) begin
        ibuf[wr_ptr] <= '{instr: imem_rsp_data_if, pc: rsp_pc};
        wr_ptr       <= wr_ptr + 1'b1;
        rsp_pc       <= rsp_pc + 32'd4;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

`ifndef SYNTHESIS
  a_rsp_expected: assert property (@(posedge clk) disable iff (reset)
    imem_rsp_valid_if |-> (outstanding != '0 || drop_cnt != '0));
  a_count_bound: assert property (@(posedge clk) disable iff (reset)
    count <= CW'(IBUF_DEPTH));
`endif
endmodule
